// File: rtl/periph_bus_arbiter_pkg.sv
// Shared definitions for the two-master peripheral bus arbiter: FSM state
// encoding, the peripheral window base and an owner-decode helper.
package periph_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_t;

  localparam logic [31:0] PERIPH_BASE = 32'h4000_0000;
  localparam int          STAT_W      = 16;

  // Master index that owns the bus in an owner state (1 only for ST_OWN1).
  function automatic logic owner_of(arb_state_t s);
    return (s == ST_OWN1);
  endfunction

endpackage

// File: rtl/periph_bus_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; serves the hold counter and
// the optional statistics counters.
module arb_sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/periph_bus_arbiter.sv
// Round-robin arbiter sharing the peripheral register bus between the CPU
// (master 0) and a secondary engine (master 1). Define ARB_STATS_EN for counters.
module periph_bus_arbiter
  import periph_bus_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m1_req,
  input  logic        m0_rd,
  input  logic        m1_rd,
  input  logic        m0_wr,
  input  logic        m1_wr,
  input  logic        m0_lock,
  input  logic        m1_lock,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m0_wdata,
  input  logic [31:0] m1_wdata,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic [31:0] m0_rdata,
  output logic [31:0] m1_rdata,
  output logic        m0_rvalid,
  output logic        m1_rvalid,
  output logic        p_rd,
  output logic        p_wr,
  output logic [31:0] p_addr,
  output logic [31:0] p_wdata,
  input  logic [31:0] p_rdata,
  output logic [15:0] stat_gnt0,
  output logic [15:0] stat_gnt1,
  output logic [15:0] stat_conflict
);

  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD - 1);

  arb_state_t        state;
  arb_state_t        next_state;
  logic              last_owner;
  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_ok;
  logic              hold_clear;
  logic              hold_inc;

  assign hold_ok = (hold_cnt < HOLD_LIMIT);

  // A locked owner keeps the bus under contention only until the hold limit.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (m0_req && m1_req) next_state = last_owner ? ST_OWN0 : ST_OWN1;
        else if (m0_req)      next_state = ST_OWN0;
        else if (m1_req)      next_state = ST_OWN1;
        else                  next_state = ST_IDLE;
      end
      ST_OWN0: begin
        if (m0_req && (!m1_req || (m0_lock && hold_ok))) next_state = ST_OWN0;
        else if (m1_req)                                 next_state = ST_OWN1;
        else                                             next_state = ST_IDLE;
      end
      ST_OWN1: begin
        if (m1_req && (!m0_req || (m1_lock && hold_ok))) next_state = ST_OWN1;
        else if (m0_req)                                 next_state = ST_OWN0;
        else                                             next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  assign hold_clear = (next_state != state) || (next_state == ST_IDLE);
  assign hold_inc   = (state != ST_IDLE);

  arb_sat_counter #(.W(HOLD_W)) u_hold_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (hold_clear),
    .inc   (hold_inc),
    .count (hold_cnt)
  );

  assign m0_gnt = (state == ST_OWN0);
  assign m1_gnt = (state == ST_OWN1);

  // Strobes are gated by the owner's own req; write wins over read.
  always_comb begin
    p_rd    = 1'b0;
    p_wr    = 1'b0;
    p_addr  = '0;
    p_wdata = '0;
    case (state)
      ST_OWN0: begin
        p_rd    = m0_req & m0_rd & ~m0_wr;
        p_wr    = m0_req & m0_wr;
        p_addr  = m0_addr;
        p_wdata = m0_wdata;
      end
      ST_OWN1: begin
        p_rd    = m1_req & m1_rd & ~m1_wr;
        p_wr    = m1_req & m1_wr;
        p_addr  = m1_addr;
        p_wdata = m1_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      last_owner <= 1'b1;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
      m0_rvalid  <= 1'b0;
      m1_rvalid  <= 1'b0;
    end else begin
      state <= next_state;
      if (next_state != ST_IDLE) last_owner <= owner_of(next_state);
      m0_rvalid <= m0_gnt && p_rd;
      m1_rvalid <= m1_gnt && p_rd;
      if (m0_gnt && p_rd) m0_rdata <= p_rdata;
      if (m1_gnt && p_rd) m1_rdata <= p_rdata;
    end
  end

`ifdef ARB_STATS_EN
  logic xfer0;
  logic xfer1;
  logic conflict;

  assign xfer0    = m0_gnt & (p_rd | p_wr);
  assign xfer1    = m1_gnt & (p_rd | p_wr);
  assign conflict = m0_req & m1_req;

  arb_sat_counter #(.W(STAT_W)) u_stat_gnt0 (
    .clk(clk), .reset(reset), .clear(1'b0), .inc(xfer0), .count(stat_gnt0)
  );
  arb_sat_counter #(.W(STAT_W)) u_stat_gnt1 (
    .clk(clk), .reset(reset), .clear(1'b0), .inc(xfer1), .count(stat_gnt1)
  );
  arb_sat_counter #(.W(STAT_W)) u_stat_conflict (
    .clk(clk), .reset(reset), .clear(1'b0), .inc(conflict), .count(stat_conflict)
  );
`else
  assign stat_gnt0     = '0;
  assign stat_gnt1     = '0;
  assign stat_conflict = '0;
`endif

endmodule
